cosim_ep_arbiter: RTL

Shares one cosim endpoint message channel among `NUM_REQ` requesters. Outgoing messages are merged round-robin into a single registered stream toward the endpoint's DataIn side. The endpoint returns responses in request order, so each response on its DataOut side is routed back to the requester whose message it answers, using an in-order tag FIFO. The block sits between testbench-side or DUT-side message producers and a single `Cosim_Endpoint` instance.

---
 rtl/cosim_ep_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/cosim_ep_arbiter.sv
// Round-robin merge of NUM_REQ message producers onto one cosim endpoint; 1-cycle registered request path,
// 0-cycle response path. Requests stall on endpoint backpressure or a full tag FIFO; responses stall per head requester.
module cosim_ep_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TYPE_SIZE_BITS = 1026,
  parameter int OUTSTANDING    = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*TYPE_SIZE_BITS-1:0]   req_data,
  output logic                                ep_in_valid,
  input  logic                                ep_in_ready,
  output logic [TYPE_SIZE_BITS-1:0]           ep_in_data,
  input  logic                                ep_out_valid,
  output logic                                ep_out_ready,
  input  logic [TYPE_SIZE_BITS-1:0]           ep_out_data,
  output logic [NUM_REQ-1:0]                  resp_valid,
  input  logic [NUM_REQ-1:0]                  resp_ready,
  output logic [TYPE_SIZE_BITS-1:0]           resp_data,
  output logic [$clog2(OUTSTANDING+1)-1:0]    outstanding,
  output logic                                err_unexpected_resp
);

  localparam int TW = $clog2(NUM_REQ);
  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = $clog2(OUTSTANDING+1);

  logic [TW-1:0] last_grant;
  logic [TW-1:0] grant_idx;
  logic          grant_found;
  logic          can_accept;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [TW-1:0] head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [TW-1:0] tag_mem [OUTSTANDING];

  // Search order starts just after the previous winner; no lock is held across cycles.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = TW'(idx);
      end
    end
  end

  // A pop in the same cycle does not free a slot for an accept: the full check uses the registered count.
  assign can_accept = (!ep_in_valid || ep_in_ready) && (outstanding != CW'(OUTSTANDING));
  assign push       = can_accept && grant_found;
  assign req_ready  = push ? (NUM_REQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ep_in_valid <= 1'b0;
      last_grant  <= TW'(NUM_REQ-1);
    end else if (push) begin
      ep_in_valid <= 1'b1;
      last_grant  <= grant_idx;
    end else if (ep_in_ready) begin
      ep_in_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ep_in_data <= req_data[grant_idx*TYPE_SIZE_BITS +: TYPE_SIZE_BITS];
    end
  end

  assign fifo_empty = (outstanding == '0);
  assign head       = tag_mem[rd_ptr];
  assign resp_data  = ep_out_data;

  // With nothing outstanding the endpoint's response is swallowed and flagged.
  always_comb begin
    resp_valid   = '0;
    ep_out_ready = 1'b1;
    pop          = 1'b0;
    if (!fifo_empty) begin
      resp_valid   = NUM_REQ'(ep_out_valid) << head;
      ep_out_ready = resp_ready[head];
      pop          = ep_out_valid && resp_ready[head];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      outstanding         <= '0;
      err_unexpected_resp <= 1'b0;
    end else begin
      err_unexpected_resp <= ep_out_valid && fifo_empty;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
